pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline register that replaces the fixed per-stage latches between pipeline stages (IF/ID … MEM/WB). It carries an opaque payload through DEPTH register slices using a valid/ready handshake. It supports a whole-stage hold, a flush that kills in-flight beats, and an optional skid entry that makes `in_ready` a pure flop output. Saturating stall and flush counters feed the CPU debug/perf view.

---
 rtl/pipe_stage_pkg.sv | 21 ++
 rtl/pipe_slice.sv | 37 +++
 rtl/pipe_stage_reg.sv | 148 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared types and helpers for the elastic pipeline stage register.
// memwb_t is the default payload bundle between the MEM and WB stages.
package pipe_stage_pkg;

    localparam int DEPTH_MAX = 4;

    // Bit positions: pc4[103:72] rd[71:67] alu[66:35] dmem[34:3] mem_to_reg[2:1] reg_write[0]
    typedef struct packed {
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] dmem;
        logic [1:0]  mem_to_reg;
        logic        reg_write;
    } memwb_t;

    function automatic int occ_w(input int depth, input int skid);
        return $clog2(depth + skid + 1);
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// One {valid, data} register: clear kills valid only, load copies the source, otherwise it holds.
// Zero added latency beyond its own flop; no flow control of its own (the parent decides when to load).
module pipe_slice #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_clr,
    input  logic              i_ld,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_dat,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_dat
);

    logic              r_vld;
    logic [DATA_W-1:0] r_dat;

    // Data is only written with a valid source so bubbles never disturb the payload register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (i_clr) begin
            r_vld <= 1'b0;
        end else if (i_ld) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_dat <= i_dat;
            end
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic DEPTH-slice pipeline register with hold, flush, optional skid entry and perf counters.
// Latency DEPTH cycles (+1 via skid); in_ready falls when full, combinationally (SKID=0) or registered (SKID=1).
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W = $bits(memwb_t),
    parameter int DEPTH  = 1,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
) (
    input  logic                            clk_Stage,
    input  logic                            rstn_Stage,
    input  logic                            in_valid_Stage,
    output logic                            in_ready_Stage,
    input  logic [DATA_W-1:0]               in_data_Stage,
    input  logic                            hold_Stage,
    input  logic                            flush_Stage,
    output logic                            out_valid_Stage,
    input  logic                            out_ready_Stage,
    output logic [DATA_W-1:0]               out_data_Stage,
    output logic [occ_w(DEPTH, SKID)-1:0]   occupancy_Stage,
    output logic [CNT_W-1:0]                stall_cnt_Stage,
    output logic [CNT_W-1:0]                flush_cnt_Stage
);

    localparam int DEPTH_C = (DEPTH > DEPTH_MAX) ? DEPTH_MAX : ((DEPTH < 1) ? 1 : DEPTH);
    localparam int OCC_W   = occ_w(DEPTH, SKID);

    logic [DEPTH_C-1:0] w_vld;
    logic [DEPTH_C-1:0] w_can_load;
    logic [DATA_W-1:0]  w_dat [DEPTH_C];
    logic               w_out_vld;
    logic               w_in_rdy;
    logic               w_acc;
    logic               w_src_vld;
    logic [DATA_W-1:0]  w_src_dat;
    logic               w_skid_vld;
    logic [OCC_W-1:0]   w_occ;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    assign w_out_vld = w_vld[DEPTH_C-1] & !hold_Stage;
    assign w_acc     = in_valid_Stage & w_in_rdy;

    // A slice may load when it is empty or its content moves on this cycle; walk from the output back.
    always_comb begin : adv_chain
        logic w_free;
        w_free     = out_ready_Stage & !hold_Stage;
        w_can_load = '0;
        for (int k = DEPTH_C - 1; k >= 0; k--) begin
            w_can_load[k] = !w_vld[k] | (w_vld[k] & w_free);
            w_free        = w_can_load[k];
        end
    end

    if (SKID != 0) begin : g_skid
        logic              r_rst_done;
        logic              w_skid_ld;
        logic              w_skid_in_vld;
        logic [DATA_W-1:0] w_skid_dat;

        always_ff @(posedge clk_Stage) begin
            if (!rstn_Stage) begin
                r_rst_done <= 1'b0;
            end else begin
                r_rst_done <= 1'b1;
            end
        end

        // A full skid drains into slice 0 ahead of any new input; an empty one catches a beat slice 0 refused.
        assign w_in_rdy      = r_rst_done & !w_skid_vld & !hold_Stage & !flush_Stage;
        assign w_skid_ld     = !hold_Stage & (w_skid_vld ? w_can_load[0] : 1'b1);
        assign w_skid_in_vld = !w_skid_vld & w_acc & !w_can_load[0];
        assign w_src_vld     = w_skid_vld | w_acc;
        assign w_src_dat     = w_skid_vld ? w_skid_dat : in_data_Stage;

        pipe_slice #(.DATA_W(DATA_W)) u_skid (
            .clk   (clk_Stage),
            .rstn  (rstn_Stage),
            .i_clr (flush_Stage),
            .i_ld  (w_skid_ld),
            .i_vld (w_skid_in_vld),
            .i_dat (in_data_Stage),
            .o_vld (w_skid_vld),
            .o_dat (w_skid_dat)
        );
    end else begin : g_noskid
        assign w_skid_vld = 1'b0;
        assign w_in_rdy   = !hold_Stage & !flush_Stage & w_can_load[0];
        assign w_src_vld  = w_acc;
        assign w_src_dat  = in_data_Stage;
    end

    for (genvar k = 0; k < DEPTH_C; k++) begin : g_slice
        logic              w_ld_vld;
        logic [DATA_W-1:0] w_ld_dat;

        if (k == 0) begin : g_head
            assign w_ld_vld = w_src_vld;
            assign w_ld_dat = w_src_dat;
        end else begin : g_body
            assign w_ld_vld = w_vld[k-1];
            assign w_ld_dat = w_dat[k-1];
        end

        pipe_slice #(.DATA_W(DATA_W)) u_slice (
            .clk   (clk_Stage),
            .rstn  (rstn_Stage),
            .i_clr (flush_Stage),
            .i_ld  (!hold_Stage & w_can_load[k]),
            .i_vld (w_ld_vld),
            .i_dat (w_ld_dat),
            .o_vld (w_vld[k]),
            .o_dat (w_dat[k])
        );
    end

    always_comb begin
        w_occ = '0;
        for (int k = 0; k < DEPTH_C; k++) begin
            w_occ = w_occ + OCC_W'(w_vld[k]);
        end
        w_occ = w_occ + OCC_W'(w_skid_vld);
    end

    // Hold already forces out_valid low, so the stall counter freezes on its own; flushes count regardless.
    always_ff @(posedge clk_Stage) begin
        if (!rstn_Stage) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_out_vld && !out_ready_Stage && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flush_Stage && (w_occ != '0) && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready_Stage  = w_in_rdy;
    assign out_valid_Stage = w_out_vld;
    assign out_data_Stage  = w_dat[DEPTH_C-1];
    assign occupancy_Stage = w_occ;
    assign stall_cnt_Stage = r_stall_cnt;
    assign flush_cnt_Stage = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Three stage variants (D1/S0, D3/S0, D3/S1 with 4-bit counters) checked against per-variant scoreboards.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn  [3];
    logic        iv    [3];
    logic        hold  [3];
    logic        flush [3];
    logic        ordy  [3];
    logic [15:0] idat  [3];
    logic        ir    [3];
    logic        ov    [3];
    logic [15:0] odat  [3];
    logic [2:0]  occ   [3];
    logic [15:0] stl   [3];
    logic [15:0] fct   [3];

    logic [0:0]  occ0_w;
    logic [1:0]  occ1_w;
    logic [2:0]  occ2_w;
    logic [15:0] stl0_w, fct0_w, stl1_w, fct1_w;
    logic [3:0]  stl2_w, fct2_w;

    assign occ[0] = {2'b00, occ0_w};
    assign occ[1] = {1'b0, occ1_w};
    assign occ[2] = occ2_w;
    assign stl[0] = stl0_w;
    assign fct[0] = fct0_w;
    assign stl[1] = stl1_w;
    assign fct[1] = fct1_w;
    assign stl[2] = {12'h000, stl2_w};
    assign fct[2] = {12'h000, fct2_w};

    pipe_stage_reg #(.DATA_W(16), .DEPTH(1), .SKID(0), .CNT_W(16)) u_dut0 (
        .clk_Stage(clk), .rstn_Stage(rstn[0]), .in_valid_Stage(iv[0]), .in_ready_Stage(ir[0]),
        .in_data_Stage(idat[0]), .hold_Stage(hold[0]), .flush_Stage(flush[0]),
        .out_valid_Stage(ov[0]), .out_ready_Stage(ordy[0]), .out_data_Stage(odat[0]),
        .occupancy_Stage(occ0_w), .stall_cnt_Stage(stl0_w), .flush_cnt_Stage(fct0_w));

    pipe_stage_reg #(.DATA_W(16), .DEPTH(3), .SKID(0), .CNT_W(16)) u_dut1 (
        .clk_Stage(clk), .rstn_Stage(rstn[1]), .in_valid_Stage(iv[1]), .in_ready_Stage(ir[1]),
        .in_data_Stage(idat[1]), .hold_Stage(hold[1]), .flush_Stage(flush[1]),
        .out_valid_Stage(ov[1]), .out_ready_Stage(ordy[1]), .out_data_Stage(odat[1]),
        .occupancy_Stage(occ1_w), .stall_cnt_Stage(stl1_w), .flush_cnt_Stage(fct1_w));

    pipe_stage_reg #(.DATA_W(16), .DEPTH(3), .SKID(1), .CNT_W(4)) u_dut2 (
        .clk_Stage(clk), .rstn_Stage(rstn[2]), .in_valid_Stage(iv[2]), .in_ready_Stage(ir[2]),
        .in_data_Stage(idat[2]), .hold_Stage(hold[2]), .flush_Stage(flush[2]),
        .out_valid_Stage(ov[2]), .out_ready_Stage(ordy[2]), .out_data_Stage(odat[2]),
        .occupancy_Stage(occ2_w), .stall_cnt_Stage(stl2_w), .flush_cnt_Stage(fct2_w));

    int n_checks = 0;
    int n_errors = 0;
    int rx [3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboards: push on accepted input, pop on output transfer, drop everything on flush/reset.
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rstn[0]) q0.delete();
        else begin
            if (ov[0] && ordy[0]) begin
                e = (q0.size() != 0) ? {16'h0, q0.pop_front()} : 32'hxxxxxxxx;
                check_eq("d0_out_data", {16'h0, odat[0]}, e);
                rx[0]++;
            end
            if (flush[0]) q0.delete();
            else if (iv[0] && ir[0]) q0.push_back(idat[0]);
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rstn[1]) q1.delete();
        else begin
            if (ov[1] && ordy[1]) begin
                e = (q1.size() != 0) ? {16'h0, q1.pop_front()} : 32'hxxxxxxxx;
                check_eq("d1_out_data", {16'h0, odat[1]}, e);
                rx[1]++;
            end
            if (flush[1]) q1.delete();
            else if (iv[1] && ir[1]) q1.push_back(idat[1]);
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rstn[2]) q2.delete();
        else begin
            if (ov[2] && ordy[2]) begin
                e = (q2.size() != 0) ? {16'h0, q2.pop_front()} : 32'hxxxxxxxx;
                check_eq("d2_out_data", {16'h0, odat[2]}, e);
                rx[2]++;
            end
            if (flush[2]) q2.delete();
            else if (iv[2] && ir[2]) q2.push_back(idat[2]);
        end
    end

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        int base;
        logic acc;
        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b0; iv[i] = 1'b0; hold[i] = 1'b0; flush[i] = 1'b0;
            ordy[i] = 1'b1; idat[i] = '0; rx[i] = 0;
        end

        // Reset state
        step_cyc();
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_out_valid", ov[i], 0);
            check_eq("rst_out_data", odat[i], 0);
            check_eq("rst_occupancy", occ[i], 0);
            check_eq("rst_stall_cnt", stl[i], 0);
            check_eq("rst_flush_cnt", fct[i], 0);
        end
        check_eq("rst_in_ready_s0", ir[0], 1);
        check_eq("rst_in_ready_s1", ir[2], 0);
        for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
        step_cyc();
        #1;
        check_eq("post_rst_in_ready_s1", ir[2], 1);

        // DEPTH=1 streaming: each beat visible the cycle after its acceptance edge
        for (int k = 1; k <= 8; k++) begin
            iv[0] = 1'b1; idat[0] = 16'(k);
            #1;
            check_eq("d0_in_ready", ir[0], 1);
            if (k > 1) begin
                check_eq("d0_lat_valid", ov[0], 1);
                check_eq("d0_lat_data", odat[0], 32'(k - 1));
            end
            step_cyc();
        end
        iv[0] = 1'b0;
        #1;
        check_eq("d0_last_valid", ov[0], 1);
        check_eq("d0_last_data", odat[0], 8);
        step_cyc();
        #1;
        check_eq("d0_idle_valid", ov[0], 0);
        check_eq("d0_stall_cnt", stl[0], 0);
        check_eq("d0_rx_count", rx[0], 8);
        check_eq("d0_sb_empty", q0.size(), 0);

        // DEPTH=3 back-pressure: fill, stall 5 cycles, release with simultaneous push/pop
        nv = 'h11;
        for (int c = 0; c < 11; c++) begin
            iv[1] = 1'b1; idat[1] = 16'(nv); ordy[1] = (c >= 8);
            #1;
            if (c < 3) check_eq("d1_fill_in_ready", ir[1], 1);
            if (c >= 3 && c <= 7) begin
                check_eq("d1_full_in_ready", ir[1], 0);
                check_eq("d1_full_occ", occ[1], 3);
            end
            if (c == 8) begin
                check_eq("d1_stall_cnt", stl[1], 5);
                check_eq("d1_pushpop_in_ready", ir[1], 1);
            end
            acc = iv[1] & ir[1];
            step_cyc();
            if (acc) nv++;
        end
        iv[1] = 1'b0;
        repeat (5) step_cyc();
        #1;
        check_eq("d1_rx_count", rx[1], nv - 'h11);
        check_eq("d1_sb_empty", q1.size(), 0);
        check_eq("d1_stall_after", stl[1], 5);

        // SKID=1: one extra beat parks in the skid, in_ready falls the following cycle
        nv = 'h21;
        for (int c = 0; c < 13; c++) begin
            iv[2] = 1'b1; idat[2] = 16'(nv); ordy[2] = !(c >= 4 && c <= 7);
            #1;
            if (c == 4) begin
                check_eq("d2_skid_in_ready", ir[2], 1);
                check_eq("d2_pre_skid_occ", occ[2], 3);
            end
            if (c == 5) begin
                check_eq("d2_full_in_ready", ir[2], 0);
                check_eq("d2_full_occ", occ[2], 4);
                check_eq("d2_one_extra", nv, 'h26);
            end
            if (c == 8) begin
                check_eq("d2_drain_in_ready", ir[2], 0);
                check_eq("d2_stall_cnt", stl[2], 4);
            end
            if (c == 9) check_eq("d2_reopen_in_ready", ir[2], 1);
            acc = iv[2] & ir[2];
            step_cyc();
            if (acc) nv++;
        end
        iv[2] = 1'b0;
        repeat (8) step_cyc();
        #1;
        check_eq("d2_rx_count", rx[2], nv - 'h21);
        check_eq("d2_sb_empty", q2.size(), 0);

        // Flush with two beats in flight; 0xAA must be refused
        ordy[1] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            iv[1] = 1'b1; idat[1] = 16'h31 + 16'(c);
            step_cyc();
        end
        iv[1] = 1'b0;
        #1;
        check_eq("d1_pre_flush_occ", occ[1], 2);
        step_cyc();
        iv[1] = 1'b1; idat[1] = 16'h00AA; flush[1] = 1'b1;
        #1;
        check_eq("d1_flush_in_ready", ir[1], 0);
        step_cyc();
        iv[1] = 1'b0; flush[1] = 1'b0;
        #1;
        check_eq("d1_post_flush_occ", occ[1], 0);
        check_eq("d1_flush_cnt", fct[1], 1);
        flush[1] = 1'b1;
        step_cyc();
        flush[1] = 1'b0;
        #1;
        check_eq("d1_empty_flush_cnt", fct[1], 1);
        ordy[1] = 1'b1;
        repeat (4) step_cyc();
        #1;
        check_eq("d1_flush_sb_empty", q1.size(), 0);

        // Hold for 4 cycles mid-stream (stall count includes the flush cycle above)
        nv = 'h41;
        base = rx[1];
        for (int c = 0; c < 12; c++) begin
            iv[1] = 1'b1; idat[1] = 16'(nv); hold[1] = (c >= 5 && c <= 8);
            #1;
            if (c >= 5 && c <= 8) begin
                check_eq("d1_hold_out_valid", ov[1], 0);
                check_eq("d1_hold_in_ready", ir[1], 0);
                check_eq("d1_hold_occ", occ[1], 3);
                check_eq("d1_hold_stall", stl[1], 6);
            end
            acc = iv[1] & ir[1];
            step_cyc();
            if (acc) nv++;
        end
        iv[1] = 1'b0; hold[1] = 1'b0;
        repeat (5) step_cyc();
        #1;
        check_eq("d1_hold_rx", rx[1] - base, nv - 'h41);
        check_eq("d1_hold_sb_empty", q1.size(), 0);

        // Flush together with hold empties the stage
        ordy[1] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            iv[1] = 1'b1; idat[1] = 16'h51 + 16'(c);
            step_cyc();
        end
        hold[1] = 1'b1; flush[1] = 1'b1;
        #1;
        check_eq("d1_fh_out_valid", ov[1], 0);
        check_eq("d1_fh_in_ready", ir[1], 0);
        step_cyc();
        iv[1] = 1'b0; hold[1] = 1'b0; flush[1] = 1'b0;
        #1;
        check_eq("d1_fh_occ", occ[1], 0);
        check_eq("d1_fh_flush_cnt", fct[1], 2);
        ordy[1] = 1'b1;
        repeat (4) step_cyc();
        #1;
        check_eq("d1_fh_sb_empty", q1.size(), 0);
        check_eq("d1_fh_stall", stl[1], 6);

        // 4-bit stall counter saturates, then reset mid-stream clears everything
        ordy[2] = 1'b0;
        for (int c = 0; c < 24; c++) begin
            iv[2] = 1'b1; idat[2] = 16'(nv);
            acc = 1'b0;
            #1;
            acc = iv[2] & ir[2];
            step_cyc();
            if (acc) nv++;
        end
        iv[2] = 1'b0;
        #1;
        check_eq("d2_stall_sat", stl[2], 15);
        check_eq("d2_sat_occ", occ[2], 4);
        check_eq("d2_sat_in_ready", ir[2], 0);
        check_eq("d2_sat_sb_depth", q2.size(), 4);
        flush[2] = 1'b1;
        step_cyc();
        flush[2] = 1'b0;
        #1;
        check_eq("d2_flush_cnt", fct[2], 1);
        check_eq("d2_flush_occ", occ[2], 0);
        for (int c = 0; c < 2; c++) begin
            iv[2] = 1'b1; idat[2] = 16'h71 + 16'(c);
            step_cyc();
        end
        iv[2] = 1'b0; rstn[2] = 1'b0;
        step_cyc();
        #1;
        check_eq("d2_rst_occ", occ[2], 0);
        check_eq("d2_rst_stall", stl[2], 0);
        check_eq("d2_rst_flush", fct[2], 0);
        check_eq("d2_rst_out_valid", ov[2], 0);
        check_eq("d2_rst_in_ready", ir[2], 0);
        rstn[2] = 1'b1;
        step_cyc();
        #1;
        check_eq("d2_rel_in_ready", ir[2], 1);
        ordy[2] = 1'b1;
        repeat (5) step_cyc();
        #1;
        check_eq("d2_rst_sb_empty", q2.size(), 0);
        check_eq("d2_rst_idle_valid", ov[2], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
